weight_bank_ctrl: RTL and testbench

Ping-pong weight-bank controller between tdnn_generator and a single-port, two-bank weight RAM. It serves inference reads from the active bank with 1-cycle latency and accepts coefficient-update writes into the shadow bank. On a commit, it swaps banks only at a safe inference boundary, then (optionally) copies the new active bank into the new shadow bank so later partial updates stay consistent.

---
 rtl/wbank_pkg.sv | 20 ++
 rtl/weight_bank_ctrl.sv | 151 +++++++++++++++
 tb/tb_weight_bank_ctrl.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wbank_pkg.sv
// rtl/wbank_pkg.sv - shared types and constants for the ping-pong weight-bank controller
//
// Purpose : FSM state encoding, default bank depth and bank-select width
//           shared by weight_bank_ctrl and its bench.
// Ports   : none (package)
package wbank_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_SWAP = 3'd1,
    SWAP      = 3'd2,
    COPY_RD   = 3'd3,
    COPY_WR   = 3'd4,
    DONE      = 3'd5
  } state_t;

  localparam int DEFAULT_DEPTH = 1200;
  localparam int BANK_SEL_W    = 2;

endpackage

// File: rtl/weight_bank_ctrl.sv
// rtl/weight_bank_ctrl.sv - ping-pong weight-bank controller for a single-port two-bank RAM
//
// Purpose : serves TDNN reads from the active bank (1-cycle latency), accepts
//           coefficient writes into the shadow bank, and on commit swaps banks
//           at an inference boundary. With WBANK_AUTOCOPY_EN defined the new
//           active bank is then copied into the new shadow bank.
// Ports   : clk, rst (sync, active-high)
//           tdnn_start, tdnn_busy, tdnn_rd_addr -> tdnn_rd_data, weight_bank_sel
//           upd_wr_valid/upd_wr_ready/upd_wr_addr/upd_wr_data, upd_commit
//           commit_pending, commit_done, addr_err (sticky)
//           mem_addr {bank, word}, mem_we, mem_wdata, mem_rdata (1-cycle read)
// Macro   : WBANK_AUTOCOPY_EN enables the post-swap bank copy.
module weight_bank_ctrl
  import wbank_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = DEFAULT_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tdnn_start,
  input  logic                  tdnn_busy,
  input  logic [ADDR_WIDTH-1:0] tdnn_rd_addr,
  output logic [DATA_WIDTH-1:0] tdnn_rd_data,
  output logic [BANK_SEL_W-1:0] weight_bank_sel,
  input  logic                  upd_wr_valid,
  output logic                  upd_wr_ready,
  input  logic [ADDR_WIDTH-1:0] upd_wr_addr,
  input  logic [DATA_WIDTH-1:0] upd_wr_data,
  input  logic                  upd_commit,
  output logic                  commit_pending,
  output logic                  commit_done,
  output logic                  addr_err,
  output logic [ADDR_WIDTH:0]   mem_addr,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);

  state_t                state, state_next;
  logic                  active_bank;
  logic                  rd_pending;   // previous cycle was a TDNN read
  logic [DATA_WIDTH-1:0] rd_hold;
  logic                  wr_fire;
  logic                  wr_in_range;

`ifdef WBANK_AUTOCOPY_EN
  localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(DEPTH-1);
  logic [ADDR_WIDTH-1:0] cnt;
  logic [DATA_WIDTH-1:0] copy_buf;
  logic                  rd_fresh;     // mem_rdata this cycle is the copy read
`endif

  assign wr_fire         = upd_wr_valid & upd_wr_ready;
  assign wr_in_range     = {1'b0, upd_wr_addr} < DEPTH_W;
  assign weight_bank_sel = {1'b0, active_bank};
  // Live RAM data right after a TDNN read; otherwise hold the last result.
  assign tdnn_rd_data    = rd_pending ? mem_rdata : rd_hold;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic; copy states only advance when the TDNN leaves the slot free
  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (upd_commit) state_next = WAIT_SWAP;
      WAIT_SWAP: if (!tdnn_busy && !tdnn_start) state_next = SWAP;
`ifdef WBANK_AUTOCOPY_EN
      SWAP:      state_next = COPY_RD;
      COPY_RD:   if (!tdnn_busy) state_next = COPY_WR;
      COPY_WR:   if (!tdnn_busy) state_next = (cnt == LAST_WORD) ? DONE : COPY_RD;
`else
      SWAP:      state_next = DONE;
`endif
      DONE:      state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Outputs and RAM slot mux; the TDNN always wins the slot
  always_comb begin
    upd_wr_ready   = 1'b0;
    mem_we         = 1'b0;
    mem_addr       = {active_bank, tdnn_rd_addr};
    mem_wdata      = upd_wr_data;
    commit_pending = (state == WAIT_SWAP) || (state == SWAP) ||
                     (state == COPY_RD)   || (state == COPY_WR);
    commit_done    = (state == DONE);
    if (state == IDLE) upd_wr_ready = ~tdnn_busy & ~rst;
    if (!tdnn_busy && !rst) begin
      case (state)
        IDLE: begin
          // Out-of-range writes are accepted but never reach the RAM
          if (wr_fire && wr_in_range) begin
            mem_we   = 1'b1;
            mem_addr = {~active_bank, upd_wr_addr};
          end
        end
`ifdef WBANK_AUTOCOPY_EN
        COPY_RD: mem_addr = {active_bank, cnt};
        COPY_WR: begin
          mem_we    = 1'b1;
          mem_addr  = {~active_bank, cnt};
          mem_wdata = rd_fresh ? mem_rdata : copy_buf;
        end
`endif
        default: ;
      endcase
    end
  end

  // Bank select, read-return hold and sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      active_bank <= 1'b0;
      addr_err    <= 1'b0;
      rd_pending  <= 1'b0;
      rd_hold     <= '0;
    end else begin
      rd_pending <= tdnn_busy;
      if (rd_pending) rd_hold <= mem_rdata;
      if (state == SWAP) active_bank <= ~active_bank;
      if (wr_fire && !wr_in_range) addr_err <= 1'b1;
    end
  end

`ifdef WBANK_AUTOCOPY_EN
  // Copy datapath: the read word is captured the cycle after it was issued so
  // a TDNN stall in COPY_WR cannot lose it.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      copy_buf <= '0;
      rd_fresh <= 1'b0;
    end else begin
      rd_fresh <= (state == COPY_RD) && !tdnn_busy;
      if (rd_fresh) copy_buf <= mem_rdata;
      if (state == COPY_WR && !tdnn_busy && cnt != LAST_WORD) cnt <= cnt + 1'b1;
      if (state == DONE) cnt <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_weight_bank_ctrl.sv
// tb/tb_weight_bank_ctrl.sv - directed self-checking bench for weight_bank_ctrl
module tb_weight_bank_ctrl;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int B1 = 65536;

`ifdef WBANK_AUTOCOPY_EN
  localparam int          T2_N     = 2402;
  localparam int          T3_DONE  = 2409;
  localparam int          T4_N     = 2400;
  localparam int          T6_IDLE  = 2600;
  localparam logic [15:0] B0_W0    = 16'hB000;
  localparam logic [15:0] B0_W599  = 16'hB599;
  localparam logic [15:0] B0_W1199 = 16'hB199;
  localparam logic [15:0] B0_W5    = 16'h2000;
  localparam logic [15:0] B1_W599  = 16'h3599;
`else
  localparam int          T2_N     = 2;
  localparam int          T3_DONE  = 2;
  localparam int          T4_N     = 0;
  localparam int          T6_IDLE  = 20;
  localparam logic [15:0] B0_W0    = 16'h0111;
  localparam logic [15:0] B0_W599  = 16'h0599;
  localparam logic [15:0] B0_W1199 = 16'h1199;
  localparam logic [15:0] B0_W5    = 16'h1000;
  localparam logic [15:0] B1_W599  = 16'hB599;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          tdnn_start, tdnn_busy;
  logic [AW-1:0] tdnn_rd_addr;
  logic [DW-1:0] tdnn_rd_data;
  logic [1:0]    weight_bank_sel;
  logic          upd_wr_valid, upd_wr_ready;
  logic [AW-1:0] upd_wr_addr;
  logic [DW-1:0] upd_wr_data;
  logic          upd_commit, commit_pending, commit_done, addr_err;
  logic [AW:0]   mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata, mem_rdata;

  logic [DW-1:0] ram [0:131071];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Single-port RAM, 1-cycle synchronous read
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  weight_bank_ctrl dut (
    .clk(clk), .rst(rst),
    .tdnn_start(tdnn_start), .tdnn_busy(tdnn_busy),
    .tdnn_rd_addr(tdnn_rd_addr), .tdnn_rd_data(tdnn_rd_data),
    .weight_bank_sel(weight_bank_sel),
    .upd_wr_valid(upd_wr_valid), .upd_wr_ready(upd_wr_ready),
    .upd_wr_addr(upd_wr_addr), .upd_wr_data(upd_wr_data),
    .upd_commit(upd_commit), .commit_pending(commit_pending),
    .commit_done(commit_done), .addr_err(addr_err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output int n, input int limit);
    n = 0;
    while (commit_done !== 1'b1 && n < limit) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n, swap_n, sel_bad, rdy_bad, done_cnt;

    for (int i = 0; i < 131072; i++) ram[i] = '0;
    ram[5]        = 16'h1000;
    ram[0]        = 16'h0111;
    ram[497]      = 16'h0497;
    ram[599]      = 16'h0599;
    ram[1199]     = 16'h1199;
    ram[B1+0]     = 16'hB000;
    ram[B1+497]   = 16'h0497;
    ram[B1+599]   = 16'hB599;
    ram[B1+1199]  = 16'hB199;

    rst = 1'b1; tdnn_start = 0; tdnn_busy = 0; tdnn_rd_addr = '0;
    upd_wr_valid = 0; upd_wr_addr = '0; upd_wr_data = '0; upd_commit = 0;
    tick();
    #1;
    check("ready_in_rst", 32'(upd_wr_ready), 0);
    tick();
    rst = 1'b0;
    #1;
    check("rst_sel", 32'(weight_bank_sel), 0);
    check("rst_pending", 32'(commit_pending), 0);
    check("rst_done", 32'(commit_done), 0);
    check("rst_addr_err", 32'(addr_err), 0);
    check("rst_rd_data", 32'(tdnn_rd_data), 0);
    check("rst_mem_we", 32'(mem_we), 0);
    check("idle_ready", 32'(upd_wr_ready), 1);

    // TDNN reads from bank 0
    tick();
    tdnn_busy = 1; tdnn_start = 1; tdnn_rd_addr = 16'd5;
    #1;
    check("rd_mem_addr", 32'(mem_addr), 32'h00005);
    check("rd_sel", 32'(weight_bank_sel), 0);
    tick();
    tdnn_start = 0;
    #1;
    check("rd_data_w5", 32'(tdnn_rd_data), 32'h1000);
    tick();
    tdnn_rd_addr = 16'd0;
    tick();
    tdnn_busy = 0; tdnn_rd_addr = 16'd599;
    #1;
    check("rd_data_w0", 32'(tdnn_rd_data), 32'h0111);
    tick();
    check("rd_hold", 32'(tdnn_rd_data), 32'h0111);

    // Shadow write then commit
    upd_wr_valid = 1; upd_wr_addr = 16'd5; upd_wr_data = 16'h2000;
    #1;
    check("wr_ready", 32'(upd_wr_ready), 1);
    check("wr_we", 32'(mem_we), 1);
    check("wr_addr", 32'(mem_addr), 32'h10005);
    check("wr_data", 32'(mem_wdata), 32'h2000);
    tick();
    upd_wr_valid = 0; upd_commit = 1;
    #1;
    check("pre_commit_pending", 32'(commit_pending), 0);
    tick();
    upd_commit = 0;
    #1;
    check("commit_pending", 32'(commit_pending), 1);
    check("pending_ready", 32'(upd_wr_ready), 0);
    wait_done(n, 3000);
    check("t2_done_latency", 32'(n), 32'(T2_N));
    check("t2_sel", 32'(weight_bank_sel), 1);
    check("t2_pending_at_done", 32'(commit_pending), 0);
    tick();
    check("t2_done_once", 32'(commit_done), 0);
    check("t2_b0_w0", 32'(ram[0]), 32'(B0_W0));
    check("t2_b0_w599", 32'(ram[599]), 32'(B0_W599));
    check("t2_b0_w1199", 32'(ram[1199]), 32'(B0_W1199));
    check("t2_b0_w5", 32'(ram[5]), 32'(B0_W5));
    tdnn_busy = 1; tdnn_rd_addr = 16'd5;
    #1;
    check("t2_rd_addr", 32'(mem_addr), 32'h10005);
    tick();
    tdnn_busy = 0;
    #1;
    check("t2_rd_new", 32'(tdnn_rd_data), 32'h2000);

    // Shadow is now bank 0; commit during a 600-cycle inference
    tick();
    upd_wr_valid = 1; upd_wr_addr = 16'd599; upd_wr_data = 16'h3599;
    #1;
    check("t3_wr_addr", 32'(mem_addr), 32'h00257);
    tick();
    upd_wr_valid = 0; tdnn_busy = 1; upd_commit = 1;
    #1;
    check("t3_pending0", 32'(commit_pending), 0);
    tick();
    upd_commit = 0;
    sel_bad = 0; rdy_bad = 0;
    for (int i = 1; i < 600; i++) begin
      #1;
      if (weight_bank_sel !== 2'd1) sel_bad++;
      if (upd_wr_ready !== 1'b0 || commit_pending !== 1'b1) rdy_bad++;
      tick();
    end
    check("t3_sel_stable", 32'(sel_bad), 0);
    check("t3_ready_low", 32'(rdy_bad), 0);
    swap_n = -1;
    n = 0;
    tdnn_rd_addr = 16'd5;
    while (n < 3000) begin
      tdnn_busy = ((n >= 10 && n < 14) || (n >= 1001 && n < 1004));
      #1;
      if (weight_bank_sel === 2'd0 && swap_n < 0) swap_n = n;
      if (commit_done === 1'b1) break;
      tick();
      n++;
    end
    tdnn_busy = 0;
    check("t3_swap_cycle", 32'(swap_n), 2);
    check("t3_done_latency", 32'(n), 32'(T3_DONE));
    tick();
    check("t3_b1_w599", 32'(ram[B1+599]), 32'(B1_W599));
    check("t3_b1_w497", 32'(ram[B1+497]), 32'h0497);
    check("t3_b1_w1199", 32'(ram[B1+1199]), 32'hB199);

    // Out-of-range write
    upd_wr_valid = 1; upd_wr_addr = 16'd1200; upd_wr_data = 16'hDEAD;
    #1;
    check("t5_ready", 32'(upd_wr_ready), 1);
    check("t5_no_we", 32'(mem_we), 0);
    tick();
    upd_wr_valid = 0;
    #1;
    check("t5_addr_err", 32'(addr_err), 1);
    tick(); tick(); tick();
    check("t5_sticky", 32'(addr_err), 1);

    // Write and commit in the same cycle; tdnn_start delays the swap
    upd_wr_valid = 1; upd_wr_addr = 16'd7; upd_wr_data = 16'h7777; upd_commit = 1;
    #1;
    check("t4_we", 32'(mem_we), 1);
    check("t4_addr", 32'(mem_addr), 32'h10007);
    tick();
    upd_wr_valid = 0; upd_commit = 0; tdnn_start = 1;
    tick();
    tdnn_start = 0;
    tick();
    check("t4_start_blocks", 32'(weight_bank_sel), 0);
    tick();
    check("t4_swapped", 32'(weight_bank_sel), 1);
    wait_done(n, 3000);
    check("t4_done_latency", 32'(n), 32'(T4_N));
    tick();
    tdnn_busy = 1; tdnn_rd_addr = 16'd7;
    tick();
    tdnn_busy = 0;
    #1;
    check("t4_rd_new", 32'(tdnn_rd_data), 32'h7777);
    tick();

    // Reset while a commit is in flight
`ifdef WBANK_AUTOCOPY_EN
    upd_commit = 1;
    tick();
    upd_commit = 0;
    wait_done(n, 3000);
    check("t6_first_done", 32'(n), 32'd2402);
    tick();
    upd_commit = 1;
    tick();
    upd_commit = 0;
    n = 0;
    while (mem_we !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("t6_reach_copy_wr", 32'(n), 3);
    check("t6_sel_before", 32'(weight_bank_sel), 1);
`else
    tdnn_busy = 1; upd_commit = 1;
    tick();
    upd_commit = 0;
    tick();
    check("t6_pending_before", 32'(commit_pending), 1);
    check("t6_sel_before", 32'(weight_bank_sel), 1);
    tdnn_busy = 0;
`endif
    rst = 1;
    #1;
    check("t6_ready_in_rst", 32'(upd_wr_ready), 0);
    check("t6_we_in_rst", 32'(mem_we), 0);
    tick();
    rst = 0;
    #1;
    check("t6_sel", 32'(weight_bank_sel), 0);
    check("t6_pending", 32'(commit_pending), 0);
    check("t6_idle_ready", 32'(upd_wr_ready), 1);
    done_cnt = 0;
    for (int i = 0; i < T6_IDLE; i++) begin
      if (commit_done === 1'b1) done_cnt++;
      tick();
    end
    check("t6_no_done", 32'(done_cnt), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
